// File: rtl/switch_conditioner.sv
// ============================================================================
// switch_conditioner
// ----------------------------------------------------------------------------
// Conditions the sixteen board slide switches before the processor sees them.
// Each raw level is first brought into the clock domain through a two-flop
// synchronizer, then debounced by its own counter: a new level is only
// accepted once it has been seen continuously for DEBOUNCE_CYCLES cycles.
// Every accepted change produces a one-cycle pulse on sw_changed, and can
// optionally be remembered in a sticky per-bit event flag.
//
// Optional feature:
//   SW_EVENT_LATCH_EN - when defined, builds the sticky sw_event flags and
//                       honours event_clear. When undefined, sw_event and
//                       sw_event_any are tied low, event_clear is ignored
//                       and no event flops exist.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a change
//                     (supported range 2 .. 2**CNT_W)
//   CNT_W           - width of each per-bit debounce counter
//
// Ports:
//   clock        in   system clock, everything updates on its rising edge
//   reset        in   synchronous reset, active low
//   sw_raw       in   [15:0] asynchronous switch levels from the board
//   sw           out  [15:0] debounced switch levels for the processor
//   sw_changed   out  [15:0] one-cycle pulse per bit when sw[i] toggles
//   event_clear  in   [15:0] per-bit clear of the sticky event flags
//   sw_event     out  [15:0] sticky per-bit change flags
//   sw_event_any out  OR of all sw_event bits
// ============================================================================
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] sw_raw,
    output logic [15:0] sw,
    output logic [15:0] sw_changed,
    input  logic [15:0] event_clear,
    output logic [15:0] sw_event,
    output logic        sw_event_any
);

    // Terminal count: the counter value at which a still-differing level is
    // accepted. Because the comparison is against DEBOUNCE_CYCLES-1, the
    // largest supported DEBOUNCE_CYCLES (2**CNT_W) still fits in CNT_W bits.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [15:0]      sync1;
    logic [15:0]      sync2;
    logic [CNT_W-1:0] cnt [16];
    logic [15:0]      accept;

    // Two-flop synchronizer. sw_raw comes straight off the board with no
    // relation to our clock, so nothing downstream may look at it before it
    // has passed through both stages.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // A bit is accepted on this edge when the synchronized level still
    // differs from the debounced one and its counter has already run the
    // full stable interval. The same vector drives the sw update, the
    // change pulse and the event set so that all three agree exactly.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 16; i++) begin
            accept[i] = (sync2[i] != sw[i]) && (cnt[i] == CNT_MAX);
        end
    end

    // Per-bit debounce. Each bit is either STABLE (sync2 matches sw, counter
    // held at zero) or COUNTING (sync2 differs). Any return to the old level
    // while counting clears the counter, so glitches shorter than the
    // interval vanish without trace. The counter never passes CNT_MAX:
    // reaching it with the level still different forces the acceptance
    // branch, which clears it again.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sw         <= '0;
            sw_changed <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_changed <= accept;
            for (int i = 0; i < 16; i++) begin
                if (sync2[i] == sw[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    sw[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef SW_EVENT_LATCH_EN
    logic [15:0] event_q;

    // Sticky event flags. A flag is set on the same edge that registers the
    // sw_changed pulse and stays set until software clears it. When a clear
    // and a new change land on the same edge the set wins, so a change can
    // never be lost to a clear that was aimed at an older one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            event_q <= '0;
        end else begin
            event_q <= (event_q & ~event_clear) | accept;
        end
    end

    assign sw_event = event_q;
`else
    // Without the latch there is nothing for event_clear to act on; it is
    // folded into a deliberately unused net so the port stays in place.
    logic unused_event_clear;
    assign unused_event_clear = ^event_clear;
    assign sw_event           = 16'h0000;
`endif

    // Summary flag for a single interrupt-style poll of all switches.
    assign sw_event_any = |sw_event;

endmodule

// File: tb/tb_switch_conditioner.sv
// ============================================================================
// tb_switch_conditioner
// ----------------------------------------------------------------------------
// Self-checking bench for switch_conditioner with DEBOUNCE_CYCLES = 4.
// A table of per-cycle records covers reset, a clean change and staggered
// bits; hand-written sequences cover the glitch, the event clear race and a
// reset in the middle of a count. Works with SW_EVENT_LATCH_EN defined or not.
// ============================================================================
module tb_switch_conditioner;

    localparam int DEB = 4;
    localparam int CW  = 16;

`ifdef SW_EVENT_LATCH_EN
    localparam logic [15:0] EV_MASK = 16'hFFFF;
`else
    localparam logic [15:0] EV_MASK = 16'h0000;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] sw_raw;
    logic [15:0] sw;
    logic [15:0] sw_changed;
    logic [15:0] event_clear;
    logic [15:0] sw_event;
    logic        sw_event_any;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic        rst;
        logic [15:0] raw;
        logic [15:0] clr;
        logic [15:0] exp_sw;
        logic [15:0] exp_chg;
        logic [15:0] exp_ev;
    } vec_t;

    vec_t vecs[$];

    switch_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .sw          (sw),
        .sw_changed  (sw_changed),
        .event_clear (event_clear),
        .sw_event    (sw_event),
        .sw_event_any(sw_event_any)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one cycle of inputs, lets one rising edge consume them and
    // returns 1 unit later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic rst, input logic [15:0] raw,
                                 input logic [15:0] clr);
        reset       = rst;
        sw_raw      = raw;
        event_clear = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic check16(input string name, input logic [15:0] got,
                           input logic [15:0] want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Compares all outputs; expected event values are masked off when the
    // event latch is not built.
    task automatic checkOutput(input string name, input logic [15:0] e_sw,
                               input logic [15:0] e_chg, input logic [15:0] e_ev);
        logic [15:0] ev;
        ev = e_ev & EV_MASK;
        check16({name, " sw"}, sw, e_sw);
        check16({name, " sw_changed"}, sw_changed, e_chg);
        check16({name, " sw_event"}, sw_event, ev);
        checks_total++;
        if (sw_event_any === (|ev)) checks_passed++;
        else $display("[TB] FAIL %s sw_event_any: got %b expected %b",
                      name, sw_event_any, |ev);
    endtask

    task automatic checkCount(input string name, input int bitnum,
                              input logic [CW-1:0] want);
        checks_total++;
        if (dut.cnt[bitnum] === want) checks_passed++;
        else $display("[TB] FAIL %s counter[%0d]: got %0d expected %0d",
                      name, bitnum, dut.cnt[bitnum], want);
    endtask

    function automatic void addRow(input logic rst, input logic [15:0] raw,
                                   input logic [15:0] clr, input logic [15:0] e_sw,
                                   input logic [15:0] e_chg, input logic [15:0] e_ev);
        vec_t v;
        v.rst = rst; v.raw = raw; v.clr = clr;
        v.exp_sw = e_sw; v.exp_chg = e_chg; v.exp_ev = e_ev;
        vecs.push_back(v);
    endfunction

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset         = 1'b0;
        sw_raw        = 16'h0000;
        event_clear   = 16'h0000;

        // Reset held with all switches high: nothing may leak through.
        for (int i = 0; i < 10; i++) addRow(1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0);
        // Release: first row is the first sampling edge k, accept at k+5.
        for (int i = 0; i < 5; i++) addRow(1'b1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0);
        addRow(1'b1, 16'hFFFF, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        addRow(1'b1, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0000, 16'hFFFF);
        // Back to all-zero through reset, flush the synchronizer.
        addRow(1'b0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) addRow(1'b1, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0);
        // Clean change on bit 0.
        for (int i = 0; i < 5; i++) addRow(1'b1, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0);
        addRow(1'b1, 16'h0001, 16'h0, 16'h0001, 16'h0001, 16'h0001);
        for (int i = 0; i < 2; i++) addRow(1'b1, 16'h0001, 16'h0, 16'h0001, 16'h0, 16'h0001);
        // Staggered: bit 5 first sampled at k, bit 9 at k+2.
        for (int i = 0; i < 2; i++) addRow(1'b1, 16'h0021, 16'h0, 16'h0001, 16'h0, 16'h0001);
        for (int i = 0; i < 3; i++) addRow(1'b1, 16'h0221, 16'h0, 16'h0001, 16'h0, 16'h0001);
        addRow(1'b1, 16'h0221, 16'h0, 16'h0021, 16'h0020, 16'h0021);
        addRow(1'b1, 16'h0221, 16'h0, 16'h0021, 16'h0000, 16'h0021);
        addRow(1'b1, 16'h0221, 16'h0, 16'h0221, 16'h0200, 16'h0221);
        addRow(1'b1, 16'h0221, 16'h0, 16'h0221, 16'h0000, 16'h0221);
        // Clear all flags.
        addRow(1'b1, 16'h0221, 16'hFFFF, 16'h0221, 16'h0000, 16'h0000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].raw, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_sw, vecs[i].exp_chg,
                        vecs[i].exp_ev);
        end

        // Glitch on bit 3 lasting 3 cycles: counts to 3, never accepted.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0229, 16'h0);
            checkOutput("glitch_hi", 16'h0221, 16'h0, 16'h0);
        end
        applyStimulus(1'b1, 16'h0221, 16'h0);
        checkOutput("glitch_lo1", 16'h0221, 16'h0, 16'h0);
        checkCount("glitch_lo1", 3, 16'd2);
        applyStimulus(1'b1, 16'h0221, 16'h0);
        checkCount("glitch_peak", 3, 16'd3);
        applyStimulus(1'b1, 16'h0221, 16'h0);
        checkOutput("glitch_end", 16'h0221, 16'h0, 16'h0);
        checkCount("glitch_end", 3, 16'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0221, 16'h0);
            checkOutput("glitch_after", 16'h0221, 16'h0, 16'h0);
        end

        // Clear racing the acceptance edge: set must win, next clear works.
        applyStimulus(1'b0, 16'h0000, 16'h0);
        checkOutput("ev_reset", 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0001, 16'h0);
            checkOutput("ev_wait", 16'h0, 16'h0, 16'h0);
        end
        applyStimulus(1'b1, 16'h0001, 16'h0001);
        checkOutput("ev_race", 16'h0001, 16'h0001, 16'h0001);
        applyStimulus(1'b1, 16'h0001, 16'h0001);
        checkOutput("ev_clear", 16'h0001, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 16'h0001, 16'h0000);
        checkOutput("ev_idle", 16'h0001, 16'h0000, 16'h0000);

        // Reset mid-count on bit 2, then normal acceptance afterwards.
        applyStimulus(1'b0, 16'h0000, 16'h0);
        checkOutput("mid_reset0", 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0004, 16'h0);
        checkCount("mid_before", 2, 16'd2);
        checkOutput("mid_before", 16'h0, 16'h0, 16'h0);
        applyStimulus(1'b0, 16'h0004, 16'h0);
        checkCount("mid_reset", 2, 16'd0);
        checkOutput("mid_reset", 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0004, 16'h0);
            checkOutput("mid_wait", 16'h0, 16'h0, 16'h0);
        end
        applyStimulus(1'b1, 16'h0004, 16'h0);
        checkOutput("mid_accept", 16'h0004, 16'h0004, 16'h0004);
        applyStimulus(1'b1, 16'h0004, 16'h0);
        checkOutput("mid_after", 16'h0004, 16'h0000, 16'h0004);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
